// File: rtl/scene_render.sv
`default_nettype none
// ============================================================================
// Module      : scene_render
// Description : Per-pixel colour generator for a side-scrolling bird game.
//               A snapshot of the game state is taken on frame_start. Each
//               visible pixel goes through a two-stage pipeline: region
//               compares, then a priority mux. A five-digit decimal score is
//               overlaid from a double-dabble converter.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               frame_start          - start-of-frame pulse, snapshot strobe
//               pix_valid/x/y        - visible pixel and its coordinate
//               status, bird_y       - game mode and bird position
//               pipe1..3, coin       - obstacle and coin descriptors
//               score                - binary score
//               rgb, rgb_valid       - pixel colour, two cycles after input
// Revision    : 1.0 - initial release
// ============================================================================
module scene_render (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [1:0]  status,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    input  logic [15:0] score,
    output logic [11:0] rgb,
    output logic        rgb_valid
);

    localparam logic [11:0] C_COL_DIGIT   = 12'hFFF;
    localparam logic [11:0] C_COL_BIRD_UP = 12'hFF0;
    localparam logic [11:0] C_COL_BIRD_DN = 12'hFA0;
    localparam logic [11:0] C_COL_COIN    = 12'hFD0;
    localparam logic [11:0] C_COL_HEAD    = 12'h0C0;
    localparam logic [11:0] C_COL_BODY    = 12'h080;
    localparam logic [11:0] C_COL_GROUND  = 12'hA72;
    localparam logic [11:0] C_COL_SKY     = 12'h4CF;
    localparam logic [11:0] C_COL_MENU1   = 12'hFFF;
    localparam logic [11:0] C_COL_MENU2   = 12'hF0F;

    // ------------------------------------------------------------------
    // Frame snapshot
    // ------------------------------------------------------------------
    logic [1:0]  r_status;
    logic [15:0] r_bird;
    logic [27:0] r_pipe [3];
    logic        r_coin_vis;
    logic [19:0] r_coin_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= 2'b01;
            r_bird     <= 16'd0;
            r_pipe[0]  <= 28'd0;
            r_pipe[1]  <= 28'd0;
            r_pipe[2]  <= 28'd0;
            r_coin_vis <= 1'b0;
            r_coin_pos <= 20'd0;
        end else if (frame_start) begin
            r_status   <= status;
            r_bird     <= bird_y;
            r_pipe[0]  <= pipe1[27:0];
            r_pipe[1]  <= pipe2[27:0];
            r_pipe[2]  <= pipe3[27:0];
            r_coin_vis <= coin[31];
            r_coin_pos <= coin[19:0];
        end
    end

    // ------------------------------------------------------------------
    // Score conversion (iterative double-dabble). The score snapshot is
    // loaded straight into the binary shift register on frame_start.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    conv_state_t r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [19:0] r_digits;
    logic [18:0] w_bcd_adj;

    // A 16-bit input never pushes the top digit past 6, so only the lower
    // four digits need the add-3 correction before a shift.
    for (genvar d = 0; d < 4; d++) begin : g_adj
        assign w_bcd_adj[4*d+3 -: 4] = (r_bcd[4*d+3 -: 4] >= 4'd5) ?
                                       r_bcd[4*d+3 -: 4] + 4'd3 :
                                       r_bcd[4*d+3 -: 4];
    end
    assign w_bcd_adj[18:16] = r_bcd[18:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bin    <= 16'd0;
            r_bcd    <= 20'd0;
            r_cnt    <= 4'd0;
            r_digits <= 20'd0;
        end else if (frame_start) begin
            // Also restarts a conversion already in flight.
            r_state <= ST_SHIFT;
            r_bin   <= score;
            r_bcd   <= 20'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj, r_bin[15]};
                    r_bin <= {r_bin[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_digits <= r_bcd;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: region compares (all bounds at 11 bits or wider)
    // ------------------------------------------------------------------
    function automatic logic [14:0] f_font(input logic [3:0] d);
        // 3 columns x 5 rows, top row in the MSBs, left column first.
        case (d)
            4'd0:    f_font = 15'b111_101_101_101_111;
            4'd1:    f_font = 15'b010_110_010_010_111;
            4'd2:    f_font = 15'b111_001_111_100_111;
            4'd3:    f_font = 15'b111_001_111_001_111;
            4'd4:    f_font = 15'b101_101_111_001_001;
            4'd5:    f_font = 15'b111_100_111_001_111;
            4'd6:    f_font = 15'b111_100_111_101_111;
            4'd7:    f_font = 15'b111_001_001_001_001;
            4'd8:    f_font = 15'b111_101_111_101_111;
            4'd9:    f_font = 15'b111_101_111_001_111;
            default: f_font = 15'b000_000_000_000_000;
        endcase
    endfunction

    logic [10:0] w_x, w_y;
    assign w_x = {1'b0, pix_x};
    assign w_y = {1'b0, pix_y};

    logic w_play;
    assign w_play = (r_status == 2'd0) || (r_status == 2'd3);

    // Bird: y top is 15 bits wide, so compare at 16 bits.
    logic [15:0] w_bird_end;
    logic        w_bird_hit;
    assign w_bird_end = {1'b0, r_bird[14:0]} + 16'd15;
    assign w_bird_hit = (w_x >= 11'd40) && (w_x <= 11'd55) &&
                        ({5'd0, pix_y} >= r_bird[14:0]) &&
                        ({6'd0, pix_y} <= w_bird_end);

    logic [10:0] w_cx, w_cy;
    logic        w_coin_hit;
    assign w_cx = {1'b0, r_coin_pos[9:0]};
    assign w_cy = {1'b0, r_coin_pos[19:10]};
    assign w_coin_hit = r_coin_vis &&
                        (w_x >= w_cx) && (w_x <= w_cx + 11'd15) &&
                        (w_y >= w_cy) && (w_y <= w_cy + 11'd15);

    logic [2:0] w_pipe_in;
    logic [2:0] w_pipe_head;
    for (genvar g = 0; g < 3; g++) begin : g_pipe
        logic [10:0] w_px, w_py, w_gap_end;
        assign w_px      = {1'b0, r_pipe[g][19:10]};
        assign w_py      = {1'b0, r_pipe[g][9:0]};
        assign w_gap_end = w_py + {3'd0, r_pipe[g][27:20]};
        assign w_pipe_in[g] = (w_x >= w_px) && (w_x <= w_px + 11'd49) &&
                              ((w_y < w_py) || (w_y >= w_gap_end));
        // Upper head written as y+23 >= py so rows above 0 never go negative.
        assign w_pipe_head[g] = w_pipe_in[g] &&
                                (((w_y < w_py) && (w_y + 11'd23 >= w_py)) ||
                                 ((w_y >= w_gap_end) && (w_y <= w_gap_end + 11'd22)));
    end

    // Score glyphs: digit k spans x 8+16k..19+16k, y 8..27, each font cell
    // is 4x4 pixels. Narrow arithmetic is exact inside the digit window.
    logic [6:0]  w_dx;
    logic [2:0]  w_row;
    logic        w_dig_area;
    logic [3:0]  w_dsel;
    logic [3:0]  w_fidx;
    logic [14:0] w_glyph;
    logic        w_digit_lit;

    assign w_dx       = pix_x[6:0] - 7'd8;
    assign w_row      = pix_y[4:2] - 3'd2;
    assign w_dig_area = (w_x >= 11'd8) && (w_x <= 11'd87) &&
                        (w_y >= 11'd8) && (w_y <= 11'd27) &&
                        (w_dx[3:0] < 4'd12);

    always_comb begin
        w_dsel = 4'd0;
        case (w_dx[6:4])
            3'd0:    w_dsel = r_digits[19:16];
            3'd1:    w_dsel = r_digits[15:12];
            3'd2:    w_dsel = r_digits[11:8];
            3'd3:    w_dsel = r_digits[7:4];
            3'd4:    w_dsel = r_digits[3:0];
            default: w_dsel = 4'd0;
        endcase
    end

    assign w_glyph     = f_font(w_dsel);
    assign w_fidx      = ({1'b0, w_row} * 4'd3) + {2'd0, w_dx[3:2]};
    assign w_digit_lit = w_dig_area && w_glyph[4'd14 - w_fidx];

    logic r_s1_valid, r_s1_digit, r_s1_bird, r_s1_bird_up, r_s1_coin;
    logic r_s1_head, r_s1_body, r_s1_band, r_s1_band_white, r_s1_ground;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid      <= 1'b0;
            r_s1_digit      <= 1'b0;
            r_s1_bird       <= 1'b0;
            r_s1_bird_up    <= 1'b0;
            r_s1_coin       <= 1'b0;
            r_s1_head       <= 1'b0;
            r_s1_body       <= 1'b0;
            r_s1_band       <= 1'b0;
            r_s1_band_white <= 1'b0;
            r_s1_ground     <= 1'b0;
        end else begin
            r_s1_valid      <= pix_valid;
            r_s1_digit      <= w_digit_lit;
            r_s1_bird       <= w_play && w_bird_hit;
            r_s1_bird_up    <= r_bird[15];
            r_s1_coin       <= w_play && w_coin_hit;
            r_s1_head       <= w_play && (|w_pipe_head);
            r_s1_body       <= w_play && (|w_pipe_in);
            r_s1_band       <= !w_play && (w_y >= 11'd200) && (w_y <= 11'd231);
            r_s1_band_white <= (r_status == 2'd1);
            r_s1_ground     <= (w_y >= 11'd460);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority mux
    // ------------------------------------------------------------------
    logic [11:0] w_color;
    always_comb begin
        w_color = C_COL_SKY;
        if (r_s1_digit)       w_color = C_COL_DIGIT;
        else if (r_s1_bird)   w_color = r_s1_bird_up ? C_COL_BIRD_UP : C_COL_BIRD_DN;
        else if (r_s1_coin)   w_color = C_COL_COIN;
        else if (r_s1_head)   w_color = C_COL_HEAD;
        else if (r_s1_body)   w_color = C_COL_BODY;
        else if (r_s1_band)   w_color = r_s1_band_white ? C_COL_MENU1 : C_COL_MENU2;
        else if (r_s1_ground) w_color = C_COL_GROUND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= 12'h000;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= r_s1_valid ? w_color : 12'h000;
            rgb_valid <= r_s1_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scene_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_render
// Description : Self-checking bench for scene_render. A behavioural model of
//               the rendering rules predicts every output cycle; directed
//               pixels with hand-computed colours pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_render;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [1:0]  status;
    logic [15:0] bird_y;
    logic [31:0] pipe1, pipe2, pipe3, coin;
    logic [15:0] score;
    logic [11:0] rgb;
    logic        rgb_valid;

    always #5 clk = ~clk;

    scene_render dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .status      (status),
        .bird_y      (bird_y),
        .pipe1       (pipe1),
        .pipe2       (pipe2),
        .pipe3       (pipe3),
        .coin        (coin),
        .score       (score),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid)
    );

    int checks   = 0;
    int failures = 0;

    logic [14:0] FONT [0:9] = '{
        15'b111_101_101_101_111, 15'b010_110_010_010_111,
        15'b111_001_111_100_111, 15'b111_001_111_001_111,
        15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001,
        15'b111_101_111_101_111, 15'b111_101_111_001_111
    };

    // ---------------- behavioural model ----------------
    bit          m_live = 1'b0;
    int          m_status, m_bird_top, m_coin_x, m_coin_y, m_dec;
    bit          m_bird_up, m_coin_vis;
    int          m_px [3];
    int          m_py [3];
    int          m_pg [3];
    int          conv_cnt, conv_val;
    bit          e1v, e2v;
    logic [11:0] e1c, e2c;

    function automatic logic [11:0] model_color(input int x, input int y);
        int k, ox, row, col, d, pw;
        bit hd, bd;
        if (x >= 8 && x <= 87 && y >= 8 && y <= 27) begin
            k  = (x - 8) / 16;
            ox = (x - 8) % 16;
            if (ox < 12) begin
                pw = 1;
                for (int i = 0; i < 4 - k; i++) pw = pw * 10;
                d   = (m_dec / pw) % 10;
                col = ox / 4;
                row = (y - 8) / 4;
                if (FONT[d][14 - (row * 3 + col)]) return 12'hFFF;
            end
        end
        if (m_status == 1 || m_status == 2) begin
            if (y >= 200 && y <= 231) return (m_status == 1) ? 12'hFFF : 12'hF0F;
        end else begin
            if (x >= 40 && x <= 55 && y >= m_bird_top && y <= m_bird_top + 15)
                return m_bird_up ? 12'hFF0 : 12'hFA0;
            if (m_coin_vis && x >= m_coin_x && x <= m_coin_x + 15 &&
                y >= m_coin_y && y <= m_coin_y + 15)
                return 12'hFD0;
            hd = 1'b0;
            bd = 1'b0;
            for (int n = 0; n < 3; n++) begin
                if (x >= m_px[n] && x <= m_px[n] + 49 &&
                    (y < m_py[n] || y >= m_py[n] + m_pg[n])) begin
                    if ((y < m_py[n] && y >= m_py[n] - 23) ||
                        (y >= m_py[n] + m_pg[n] && y <= m_py[n] + m_pg[n] + 22))
                        hd = 1'b1;
                    else
                        bd = 1'b1;
                end
            end
            if (hd) return 12'h0C0;
            if (bd) return 12'h080;
        end
        if (y >= 460) return 12'hA72;
        return 12'h4CF;
    endfunction

    always @(posedge clk) begin
        logic [31:0] pp [3];
        if (rst) begin
            m_live = 1'b1;
            m_status = 1; m_bird_top = 0; m_bird_up = 1'b0;
            m_coin_vis = 1'b0; m_coin_x = 0; m_coin_y = 0;
            for (int n = 0; n < 3; n++) begin
                m_px[n] = 0; m_py[n] = 0; m_pg[n] = 0;
            end
            m_dec = 0; conv_cnt = 0; conv_val = 0;
            e1v = 1'b0; e2v = 1'b0; e1c = 12'h000; e2c = 12'h000;
        end else if (m_live) begin
            e2v = e1v;
            e2c = e1c;
            e1v = pix_valid;
            e1c = pix_valid ? model_color(int'(pix_x), int'(pix_y)) : 12'h000;
            if (frame_start) begin
                pp[0] = pipe1; pp[1] = pipe2; pp[2] = pipe3;
                m_status   = int'(status);
                m_bird_top = int'(bird_y[14:0]);
                m_bird_up  = bird_y[15];
                m_coin_vis = coin[31];
                m_coin_x   = int'(coin[9:0]);
                m_coin_y   = int'(coin[19:10]);
                for (int n = 0; n < 3; n++) begin
                    m_pg[n] = int'(pp[n][27:20]);
                    m_px[n] = int'(pp[n][19:10]);
                    m_py[n] = int'(pp[n][9:0]);
                end
                conv_cnt = 17;
                conv_val = int'(score);
            end else if (conv_cnt > 0) begin
                conv_cnt = conv_cnt - 1;
                if (conv_cnt == 0) m_dec = conv_val;
            end
        end
    end

    // One compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_live) begin
            checks = checks + 1;
            if ({rgb_valid, rgb} !== {e2v, e2c}) begin
                failures = failures + 1;
                $display("FAIL stream t=%0t got valid=%0b rgb=%03h want valid=%0b rgb=%03h",
                         $time, rgb_valid, rgb, e2v, e2c);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] mkpipe(input int gap, input int x, input int y);
        return {4'd0, 8'(gap), 10'(x), 10'(y)};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got %04h want %04h", name, act, exp);
        end
    endtask

    task automatic fs();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    // Present one pixel, sample two edges later.
    task automatic px(input int x, input int y, input logic [11:0] exp, input string name);
        @(negedge clk);
        pix_x = 10'(x); pix_y = 10'(y); pix_valid = 1'b1;
        @(negedge clk) pix_valid = 1'b0;
        @(negedge clk);
        chk(name, {rgb_valid, rgb}, {1'b1, exp});
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; status = 2'd0; bird_y = '0;
        pipe1 = '0; pipe2 = '0; pipe3 = '0; coin = '0; score = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", {rgb_valid, rgb}, 13'h0000);
        rst = 1'b0;

        // Reset snapshot is menu 1 with digits 00000.
        px(300, 210, 12'hFFF, "rst_menu_band");
        px(300, 100, 12'h4CF, "rst_sky");
        px(8, 8, 12'hFFF, "rst_digit0");

        // Play scene.
        status = 2'd0; bird_y = 16'h00F0;
        pipe1 = mkpipe(100, 200, 150);
        pipe2 = mkpipe(150, 400, 100);
        pipe3 = mkpipe(50, 630, 300);
        fs();
        px(45, 245, 12'hFA0, "bird_down");
        bird_y = 16'h80F0;
        fs();
        px(45, 245, 12'hFF0, "bird_up");
        px(210, 50,  12'h080, "pipe_body_top");
        px(210, 100, 12'h080, "pipe_body_100");
        px(210, 126, 12'h080, "pipe_body_126");
        px(210, 127, 12'h0C0, "pipe_head_127");
        px(210, 130, 12'h0C0, "pipe_head_130");
        px(210, 200, 12'h4CF, "pipe_gap");
        px(210, 255, 12'h0C0, "pipe_head_low");
        px(210, 272, 12'h0C0, "pipe_head_272");
        px(210, 273, 12'h080, "pipe_body_273");
        px(210, 300, 12'h080, "pipe_body_low");
        px(249, 50,  12'h080, "pipe_right_edge");
        px(250, 50,  12'h4CF, "pipe_past_edge");
        px(639, 10,  12'h080, "pipe_nowrap");
        px(30, 40,   12'h4CF, "sky_plain");
        px(300, 459, 12'h4CF, "above_ground");
        px(300, 460, 12'hA72, "ground");

        coin = {1'b1, 11'd0, 10'd300, 10'd300};
        fs();
        px(315, 315, 12'hFD0, "coin_corner");
        px(316, 300, 12'h4CF, "coin_past");

        // Descriptor change without frame_start must not show.
        pipe1 = mkpipe(100, 500, 150);
        px(210, 50, 12'h080, "no_midframe_update");

        // Score 1234 in menu 1.
        status = 2'd1; score = 16'd1234;
        fs();
        px(44, 16, 12'h4CF, "old_digits_held");
        repeat (18) @(negedge clk);
        px(8, 8,   12'hFFF, "d0_zero_lit");
        px(24, 8,  12'h4CF, "d1_one_unlit");
        px(28, 8,  12'hFFF, "d1_one_lit");
        px(44, 16, 12'hFFF, "d2_two_lit");
        px(72, 8,  12'hFFF, "d4_four_lit");
        px(76, 8,  12'h4CF, "d4_four_unlit");
        px(300, 210, 12'hFFF, "menu1_band");
        px(210, 100, 12'h4CF, "menu_hides_pipe");

        // Aborted conversion: 5555 then 99 five cycles later.
        status = 2'd2; score = 16'd5555;
        fs();
        repeat (3) @(negedge clk);
        score = 16'd99;
        fs();
        repeat (11) @(negedge clk);
        px(40, 12, 12'h4CF, "abort_no_5555");
        repeat (10) @(negedge clk);
        px(44, 16, 12'h4CF, "d2_zero_unlit");
        px(64, 20, 12'hFFF, "d3_nine_lit");
        px(56, 20, 12'h4CF, "d3_nine_unlit");
        px(300, 210, 12'hF0F, "menu2_band");

        // Reset in the middle of a pixel stream.
        status = 2'd0;
        fs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) chk("rst_mid_next_edge", {rgb_valid, rgb}, 13'h0000);
            if (i == 8) chk("rst_release_edge", {rgb_valid, rgb}, 13'h0000);
            pix_x = 10'(200 + 3 * i); pix_y = 10'(40 + 30 * i); pix_valid = 1'b1;
            rst = (i == 4 || i == 5 || i == 6);
        end
        @(negedge clk) pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        px(300, 210, 12'hFFF, "post_rst_menu");
        px(8, 8, 12'hFFF, "post_rst_digits");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
